// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_ROL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic                 busy;
    logic [SHW-1:0]       cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod_step;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    assign sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {sum, prod[WIDTH-1:1]};
    assign done      = busy && (cnt == LAST);
    assign product   = prod_step;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            mcand <= a;
            prod  <= {{WIDTH{1'b0}}, b};
        end else if (busy) begin
            prod <= prod_step;
            cnt  <= cnt + SHW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/rotate, iterative multiply, registered result and NZCV flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [2:0]        aluOp,
    input  logic [WIDTH-1:0]  aluIn1,
    input  logic [WIDTH-1:0]  aluIn2,
    output logic              outValid,
    input  logic              outReady,
    output logic [WIDTH-1:0]  aluOut,
    output logic [WIDTH-1:0]  aluOutHi,
    output logic              N,
    output logic              Z,
    output logic              C,
    output logic              V
);

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                is_mul;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_prod;
    logic [WIDTH-1:0]    mul_hi;
    flags_t              mul_fl;

    logic [SHW-1:0]      amt;
    logic [SHW:0]        rol_shift;
    logic [WIDTH:0]      add_ext;
    logic [WIDTH:0]      sub_ext;
    logic [WIDTH-1:0]    ror_res;
    logic [WIDTH-1:0]    rol_res;
    logic [WIDTH-1:0]    single_res;
    flags_t              single_fl;

    logic [WIDTH-1:0]    out_lo;
    logic [WIDTH-1:0]    out_hi;
    flags_t              out_fl;

    assign accept = inValid && inReady;
    assign is_mul = (aluOp == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rstN    (rstN),
        .start   (accept && is_mul),
        .a       (aluIn1),
        .b       (aluIn2),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign amt       = aluIn1[SHW-1:0];
    assign add_ext   = {1'b0, aluIn1} + {1'b0, aluIn2};
    assign sub_ext   = {1'b0, aluIn2} - {1'b0, aluIn1};
    // Rotate left by amt is rotate right by WIDTH-amt; amt==0 shifts a whole copy away.
    assign rol_shift = (SHW+1)'(WIDTH) - {1'b0, amt};
    assign ror_res   = WIDTH'({aluIn2, aluIn2} >> amt);
    assign rol_res   = WIDTH'({aluIn2, aluIn2} >> rol_shift);

    always_comb begin
        single_res = '0;
        single_fl  = '0;
        case (aluOp)
            OP_ADD: begin
                single_res  = add_ext[WIDTH-1:0];
                single_fl.c = add_ext[WIDTH];
                single_fl.v = (aluIn1[WIDTH-1] == aluIn2[WIDTH-1]) &&
                              (single_res[WIDTH-1] != aluIn1[WIDTH-1]);
            end
            OP_SUB: begin
                single_res  = sub_ext[WIDTH-1:0];
                single_fl.c = ~sub_ext[WIDTH];
                single_fl.v = (aluIn2[WIDTH-1] != aluIn1[WIDTH-1]) &&
                              (single_res[WIDTH-1] != aluIn2[WIDTH-1]);
            end
            OP_ROR: begin
                single_res  = ror_res;
                single_fl.c = (amt != '0) && ror_res[WIDTH-1];
            end
            OP_ROL: begin
                single_res  = rol_res;
                single_fl.c = (amt != '0) && rol_res[0];
            end
            OP_AND:  single_res = aluIn1 & aluIn2;
            OP_OR:   single_res = aluIn1 | aluIn2;
            OP_XOR:  single_res = aluIn1 ^ aluIn2;
            default: single_res = '0;
        endcase
        single_fl.n = single_res[WIDTH-1];
        single_fl.z = (single_res == '0);
    end

    assign mul_hi   = mul_prod[2*WIDTH-1:WIDTH];
    assign mul_fl.n = mul_prod[WIDTH-1];
    assign mul_fl.z = (mul_prod == '0);
    assign mul_fl.c = (mul_hi != '0);
    assign mul_fl.v = 1'b0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        inReady    = 1'b0;
        outValid   = 1'b0;
        case (state)
            ST_IDLE: begin
                inReady = 1'b1;
                if (accept) begin
                    state_next = is_mul ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                outValid = 1'b1;
                inReady  = outReady;
                if (outReady) begin
                    if (accept) begin
                        state_next = is_mul ? ST_MUL : ST_DONE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result registers only change on a single-cycle accept or on the final multiply step.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_lo <= '0;
            out_hi <= '0;
            out_fl <= '0;
        end else if (accept && !is_mul) begin
            out_lo <= single_res;
            out_hi <= '0;
            out_fl <= single_fl;
        end else if ((state == ST_MUL) && mul_done) begin
            out_lo <= mul_prod[WIDTH-1:0];
            out_hi <= mul_hi;
            out_fl <= mul_fl;
        end
    end

    assign aluOut   = out_lo;
    assign aluOutHi = out_hi;
    assign N        = out_fl.n;
    assign Z        = out_fl.z;
    assign C        = out_fl.c;
    assign V        = out_fl.v;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected results, a negedge monitor pops and compares.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [3:0]   nzcv;
        int           acc_cyc;
        int           lat;
    } exp_t;

    logic          clk;
    logic          rstN;
    logic          inValid;
    logic          inReady;
    logic [2:0]    aluOp;
    logic [W-1:0]  aluIn1;
    logic [W-1:0]  aluIn2;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  aluOut;
    logic [W-1:0]  aluOutHi;
    logic          N, Z, C, V;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   rand_bp  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .aluOp    (aluOp),
        .aluIn1   (aluIn1),
        .aluIn2   (aluIn2),
        .outValid (outValid),
        .outReady (outReady),
        .aluOut   (aluOut),
        .aluOutHi (aluOutHi),
        .N        (N),
        .Z        (Z),
        .C        (C),
        .V        (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_bp) begin
            #2;
            outReady = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour from plain integer arithmetic and bit-at-a-time rotation.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t            e;
        longint unsigned u;
        longint          s;
        longint          smax;
        longint          smin;
        logic [W-1:0]    t;
        int              amt;
        logic            c;
        logic            v;
        logic            z;
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        e.lo = '0;
        e.hi = '0;
        e.acc_cyc = 0;
        e.lat = (op == OP_MUL) ? W + 1 : 1;
        c = 1'b0;
        v = 1'b0;
        amt = int'(a % W);
        t = b;
        case (op)
            OP_ADD: begin
                u = 64'(a) + 64'(b);
                e.lo = u[W-1:0];
                c = u[W];
                s = longint'(signed'(a)) + longint'(signed'(b));
                v = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                e.lo = b - a;
                c = (b >= a);
                s = longint'(signed'(b)) - longint'(signed'(a));
                v = (s > smax) || (s < smin);
            end
            OP_MUL: begin
                u = 64'(a) * 64'(b);
                e.lo = u[W-1:0];
                e.hi = u[2*W-1:W];
                c = (e.hi != 0);
            end
            OP_ROR: begin
                for (int i = 0; i < amt; i++) t = {t[0], t[W-1:1]};
                e.lo = t;
                c = (amt != 0) && t[W-1];
            end
            OP_ROL: begin
                for (int i = 0; i < amt; i++) t = {t[W-2:0], t[W-1]};
                e.lo = t;
                c = (amt != 0) && t[0];
            end
            OP_AND: e.lo = a & b;
            OP_OR:  e.lo = a | b;
            default: e.lo = a ^ b;
        endcase
        z = (op == OP_MUL) ? ((e.lo == 0) && (e.hi == 0)) : (e.lo == 0);
        e.nzcv = {e.lo[W-1], z, c, v};
        return e;
    endfunction

    // Holds the operation until inReady is seen at a negedge; returns 2 time units after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        exp_t q;
        bit   acc;
        q = e;
        acc = 0;
        inValid = 1'b1;
        aluOp = op;
        aluIn1 = a;
        aluIn2 = b;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (inReady) begin
                q.acc_cyc = cyc;
                sb.push_back(q);
                acc = 1;
            end
        end
        check_output("accept_within_bound", 64'(acc), 64'd1);
        @(posedge clk);
        #2;
        if (!acc) inValid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b, model(op, a, b));
    endtask

    task automatic apply_expect(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [3:0] nzcv);
        exp_t e;
        e.lo = lo;
        e.hi = hi;
        e.nzcv = nzcv;
        e.acc_cyc = 0;
        e.lat = (op == OP_MUL) ? W + 1 : 1;
        issue(op, a, b, e);
    endtask

    task automatic idle_inputs();
        inValid = 1'b0;
        aluOp = 3'($urandom);
        aluIn1 = $urandom;
        aluIn2 = $urandom;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_outValid"}, 64'(outValid), 64'd0);
        check_output({tag, "_inReady"}, 64'(inReady), 64'd1);
        check_output({tag, "_aluOut"}, 64'(aluOut), 64'd0);
        check_output({tag, "_aluOutHi"}, 64'(aluOutHi), 64'd0);
        check_output({tag, "_flags"}, 64'({N, Z, C, V}), 64'd0);
    endtask

    // Monitor: a result starts when outValid rises or follows a handshake; it retires on handshake.
    exp_t mon_e;
    bit   prev_valid = 0;
    bit   prev_hs = 0;
    int   start_cyc = 0;
    always @(negedge clk) begin
        if (!rstN) begin
            prev_valid = 0;
            prev_hs = 0;
        end else begin
            if (outValid && (!prev_valid || prev_hs)) start_cyc = cyc;
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_result: actual=%0h required=none (cycle %0d)", aluOut, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("aluOut", 64'(aluOut), 64'(mon_e.lo));
                    check_output("aluOutHi", 64'(aluOutHi), 64'(mon_e.hi));
                    check_output("nzcv", 64'({N, Z, C, V}), 64'(mon_e.nzcv));
                    check_output("latency", 64'(start_cyc - mon_e.acc_cyc), 64'(mon_e.lat));
                end
            end
            prev_valid = outValid;
            prev_hs = outValid && outReady;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] snap_lo;
        logic [W-1:0] snap_hi;
        logic [3:0]   snap_fl;
        int           cnt;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rstN = 1'b1;
        outReady = 1'b1;
        idle_inputs();
        #1 rstN = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
        @(posedge clk);
        #2;

        $display("[TB] directed single-cycle ops, back to back");
        apply_expect(OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0, 4'b0110);
        apply_expect(OP_SUB, 32'h1,         32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 4'b0011);
        apply_expect(OP_SUB, 32'h2,         32'h1,         32'hFFFF_FFFF, 32'h0, 4'b1000);
        apply_expect(OP_ROR, 32'h1,         32'h1,         32'h8000_0000, 32'h0, 4'b1010);
        apply_expect(OP_ROR, 32'd32,        32'h1,         32'h1,         32'h0, 4'b0000);
        apply_expect(OP_ROL, 32'h1,         32'h8000_0000, 32'h1,         32'h0, 4'b0010);
        idle_inputs();
        wait_drain(20);

        $display("[TB] directed multiply");
        apply_expect(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 4'b0010);
        idle_inputs();
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (inReady) cnt++;
        end
        check_output("inReady_high_during_mul", 64'(cnt), 64'd0);
        wait_drain(20);

        $display("[TB] backpressure");
        outReady = 1'b0;
        apply_stimulus(OP_ADD, 32'd5, 32'd7);
        idle_inputs();
        cnt = 0;
        for (int i = 0; i < 10 && !outValid; i++) @(negedge clk);
        check_output("outValid_under_stall", 64'(outValid), 64'd1);
        snap_lo = aluOut;
        snap_hi = aluOutHi;
        snap_fl = {N, Z, C, V};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall_stable_result", 64'({snap_hi, snap_lo}), 64'({aluOutHi, aluOut}));
            check_output("stall_stable_flags", 64'({N, Z, C, V}), 64'(snap_fl));
            check_output("stall_inReady", 64'(inReady), 64'd0);
        end
        @(posedge clk);
        #2;
        outReady = 1'b1;
        apply_expect(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 4'b0000);
        idle_inputs();
        wait_drain(20);

        $display("[TB] reset during multiply");
        apply_stimulus(OP_MUL, $urandom, $urandom);
        idle_inputs();
        repeat (10) @(posedge clk);
        #2 rstN = 1'b0;
        #1 check_reset_outputs("mid_mul_reset");
        sb.delete();
        @(posedge clk);
        #2 rstN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid) cnt++;
        end
        check_output("stale_outValid_after_reset", 64'(cnt), 64'd0);
        check_output("inReady_after_reset", 64'(inReady), 64'd1);
        @(posedge clk);
        #2;
        apply_expect(OP_ADD, 32'd2, 32'd3, 32'd5, 32'h0, 4'b0000);
        idle_inputs();
        wait_drain(20);

        $display("[TB] randomized traffic with random backpressure");
        rand_bp = 1;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ((op == OP_ROR || op == OP_ROL) && $urandom_range(0, 1) == 1) a = $urandom_range(0, 70);
            if (op == OP_MUL && $urandom_range(0, 2) == 0) b = $urandom_range(0, 255);
            if ($urandom_range(0, 15) == 0) b = '0;
            apply_stimulus(op, a, b);
            if ($urandom_range(0, 3) == 0) begin
                idle_inputs();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2;
            end
        end
        idle_inputs();
        rand_bp = 0;
        @(posedge clk);
        #2 outReady = 1'b1;
        wait_drain(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. It executes one operation per transaction on two WIDTH-bit operands and registers the result and real N/Z/C/V flags. Add, subtract, logic and rotate complete in one cycle; multiply uses an iterative shift-add engine that returns the full 2·WIDTH product. It sits between the register-read stage and writeback, and stalls via valid/ready.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 4
- SHW, $clog2(WIDTH), derived; rotate-amount bits taken from aluIn1
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- inValid  input  1  operands and opcode valid
- inReady  output  1  block can accept an operation this cycle
- aluOp  input  3  opcode (see Operation)
- aluIn1  input  WIDTH  operand 1 (subtrahend / rotate amount)
- aluIn2  input  WIDTH  operand 2 (minuend / rotated value)
- outValid  output  1  result and flags valid
- outReady  input  1  consumer accepts result
- aluOut  output  WIDTH  result (low half for multiply)
- aluOutHi  output  WIDTH  high half of product; 0 for non-multiply ops
- N, Z, C, V  output  1 each  negative, zero, carry, overflow flags

## Operation
- Opcodes: 000 add in1+in2; 001 sub in2−in1; 010 unsigned multiply in1·in2; 011 ror in2 by in1[SHW-1:0]; 100 and; 101 or; 110 xor; 111 rol in2 by in1[SHW-1:0].
- Operands and opcode are captured on accept (inValid && inReady). Later input changes have no effect on the transaction in flight.
- FSM states: IDLE, MUL, DONE.
  - IDLE: accept of a non-multiply op → DONE. Accept of a multiply → MUL.
  - MUL: one partial-product step per cycle, counter 0..WIDTH-1. After the final step → DONE.
  - DONE: hold outValid. On outReady: accept a new op if inValid; otherwise → IDLE.
- inReady = (state==IDLE) || (state==DONE && outReady). This gives back-to-back single-cycle ops at full throughput.
- N = aluOut[WIDTH-1]. Z = (aluOut==0); for multiply, Z = (full 2·WIDTH product == 0).
- add: C = carry out of bit WIDTH-1; V = signed overflow.
- sub: C = 1 when no borrow (in2 ≥ in1 unsigned); V = signed overflow of in2−in1.
- mul: C = (aluOutHi != 0); V = 0.
- ror/rol: rotate amount taken mod WIDTH. If amount==0: result = in2, C = 0. Otherwise C = last bit rotated across the boundary: ror → aluOut[WIDTH-1]; rol → aluOut[0]. V = 0.
- Logic ops: C = 0, V = 0.
- Undefined results are forbidden: every opcode drives every output.

## Timing
- Reset (async assert, sync release) forces: state IDLE, outValid 0, inReady 1, aluOut 0, aluOutHi 0, N/Z/C/V 0, counter 0.
- Reset mid-multiply abandons the transaction; no outValid is produced for it.
- Single-cycle op: accept at edge k → outValid high after edge k+1.
- Multiply: accept at edge k → outValid high after edge k+WIDTH+1 (WIDTH MUL cycles plus the DONE transition).
- Result and flags stay stable while outValid && !outReady. inReady stays low during MUL and during stalled DONE.
- A simultaneous result accept and new-op accept in DONE is legal. The next result replaces the current one at the following edge, or the block enters MUL for a multiply.

## Structure
- Shared package alu_pkg: opcode localparams (OP_ADD … OP_ROL), state enum type, flag-struct typedef {N,Z,C,V}.
- One sub-module: alu_mul_iter (shift-add multiplier with start/done, WIDTH parameter), instantiated once. Everything else stays inline in alu_seq.

## Test plan
- WIDTH=32, add in1=0xFFFFFFFF, in2=1 → aluOut=0, Z=1, C=1, V=0, N=0; outValid exactly 1 cycle after accept.
- sub in1=1, in2=0x80000000 → aluOut=0x7FFFFFFF, V=1, C=1, N=0. Then in1=2, in2=1 → 0xFFFFFFFF, C=0, N=1.
- mul in1=0x00010000, in2=0x00010000 → aluOut=0, aluOutHi=1, C=1, Z=0. outValid exactly 33 cycles after accept; inReady low throughout.
- ror in2=1, in1=1 → 0x80000000, N=1, C=1. ror in2=1, in1=32 → 1, C=0. rol in2=0x80000000, in1=1 → 1, C=1.
- Backpressure: hold outReady low 5 cycles after a result → outputs unchanged, inReady 0. Raise outReady with inValid (xor 0xF0F0F0F0 ^ 0xFF00FF00) → new result 0x0FF00FF0 on the next cycle.
- Assert rstN low at MUL cycle 10 → all outputs reach reset values immediately. After release: inReady=1, no stale outValid; a fresh add 2+3 → 5.
